// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: captures one byte plus parity flag per
// completed frame, pops on bus request, and raises a level interrupt on fill.
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned THRESH = 1
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [7:0] rx_data,
  input  logic       rx_busy,
  input  logic       rx_check_error,
  input  logic       irq_en,
  input  logic       rd_en,
  input  logic       clr,
  output logic [7:0] rd_data,
  output logic       rd_err,
  output logic       empty,
  output logic       full,
  output logic [4:0] count,
  output logic       overflow,
  output logic       irq
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 5;
  localparam int unsigned EW = 9;

  logic [EW-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_err_q, rd_err_d;

  logic push_c;
  logic pop_c;
  logic wr_en_c;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign irq      = irq_en & (count_q >= CW'(THRESH));
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;

  // A frame completes on the falling edge of rx_busy; a full FIFO only
  // accepts it when a pop frees a slot in the same cycle.
  always_comb begin
    push_c     = busy_q & ~rx_busy;
    pop_c      = rd_en & ~empty;
    wr_en_c    = push_c & (~full | pop_c);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;
    busy_d     = rx_busy;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_en_c) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_c) begin
        rd_ptr_d  = rd_ptr_q + PW'(1);
        rd_data_d = mem_q[rd_ptr_q][7:0];
        rd_err_d  = mem_q[rd_ptr_q][8];
      end
      count_d = count_q + CW'(wr_en_c) - CW'(pop_c);
      if (push_c & full & ~pop_c) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // Data storage carries no reset; only control state is reset.
  always_ff @(posedge clk) begin
    if (wr_en_c && !clr) begin
      mem_q[wr_ptr_q] <= {rx_check_error, rx_data};
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a default instance plus a THRESH=4 instance
// driven by the same stimulus, checked against hand-computed values.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rstN;
  logic [7:0] rx_data;
  logic       rx_busy;
  logic       rx_check_error;
  logic       irq_en;
  logic       rd_en;
  logic       clr;

  logic [7:0] rd_data, rd_data4;
  logic       rd_err, rd_err4;
  logic       empty, empty4;
  logic       full, full4;
  logic [4:0] count, count4;
  logic       overflow, overflow4;
  logic       irq, irq4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_fifo u_dut (
    .clk(clk), .rstN(rstN), .rx_data(rx_data), .rx_busy(rx_busy),
    .rx_check_error(rx_check_error), .irq_en(irq_en), .rd_en(rd_en), .clr(clr),
    .rd_data(rd_data), .rd_err(rd_err), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .irq(irq)
  );

  uart_rx_fifo #(.DEPTH(8), .THRESH(4)) u_dut4 (
    .clk(clk), .rstN(rstN), .rx_data(rx_data), .rx_busy(rx_busy),
    .rx_check_error(rx_check_error), .irq_en(irq_en), .rd_en(rd_en), .clr(clr),
    .rd_data(rd_data4), .rd_err(rd_err4), .empty(empty4), .full(full4),
    .count(count4), .overflow(overflow4), .irq(irq4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete frame: rx_busy high for a cycle, then low so the push lands.
  task automatic send(input logic [7:0] d, input logic e);
    rx_data = d; rx_check_error = e; rx_busy = 1'b1;
    tick();
    rx_busy = 1'b0;
    tick();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    n_cmp++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL reset_rd_err: got %b want 0", rd_err); end
  endtask

  task automatic test_single();
    irq_en = 1'b1;
    send(8'hA5, 1'b0);
    n_cmp++; if (count !== 5'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL single_irq: got %b want 1", irq); end
    pop();
    n_cmp++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_rd_data: got %h want a5", rd_data); end
    n_cmp++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL single_rd_err: got %b want 0", rd_err); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b want 1", empty); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", full); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_overflow: got %b want 0", overflow); end
    send(8'h09, 1'b0);
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow: got %b want 1", overflow); end
    n_cmp++; if (count !== 5'd8) begin n_fail++; $display("FAIL fill_count: got %0d want 8", count); end
    for (int i = 1; i <= 8; i++) begin
      pop();
      n_cmp++; if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL fill_pop%0d: got %h want %h", i, rd_data, 8'(i)); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_empty: got %b want 1", empty); end
  endtask

  task automatic test_full_push_pop();
    do_clr();
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    rx_data = 8'h55; rx_check_error = 1'b0; rx_busy = 1'b1;
    tick();
    rx_busy = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_cmp++; if (rd_data !== 8'h01) begin n_fail++; $display("FAIL fpp_rd_data: got %h want 01", rd_data); end
    n_cmp++; if (count !== 5'd8) begin n_fail++; $display("FAIL fpp_count: got %0d want 8", count); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow: got %b want 0", overflow); end
    for (int i = 2; i <= 8; i++) begin
      pop();
      n_cmp++; if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL fpp_pop%0d: got %h want %h", i, rd_data, 8'(i)); end
    end
    pop();
    n_cmp++; if (rd_data !== 8'h55) begin n_fail++; $display("FAIL fpp_last: got %h want 55", rd_data); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fpp_empty: got %b want 1", empty); end
  endtask

  task automatic test_wrap_err();
    for (int k = 1; k <= 12; k++) begin
      send(8'(8'h10 + k), (k % 3) == 0);
      pop();
      n_cmp++; if (rd_data !== 8'(8'h10 + k)) begin n_fail++; $display("FAIL wrap_data%0d: got %h want %h", k, rd_data, 8'(8'h10 + k)); end
      n_cmp++; if (rd_err !== ((k % 3) == 0)) begin n_fail++; $display("FAIL wrap_err%0d: got %b want %b", k, rd_err, (k % 3) == 0); end
    end
    pop();
    n_cmp++; if (rd_data !== 8'h1C) begin n_fail++; $display("FAIL empty_read_data: got %h want 1c", rd_data); end
    n_cmp++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL empty_read_err: got %b want 1", rd_err); end
    n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL empty_read_count: got %0d want 0", count); end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 9; i++) send(8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 3; i++) pop();
    n_cmp++; if (count !== 5'd5) begin n_fail++; $display("FAIL clr_pre_count: got %0d want 5", count); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_pre_overflow: got %b want 1", overflow); end
    rx_data = 8'h77; rx_busy = 1'b1;
    tick();
    rx_busy = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL clr_empty: got %b want 1", empty); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow: got %b want 0", overflow); end
    n_cmp++; if (rd_data !== 8'h22) begin n_fail++; $display("FAIL clr_rd_data_kept: got %h want 22", rd_data); end
    send(8'h88, 1'b0);
    pop();
    n_cmp++; if (rd_data !== 8'h88) begin n_fail++; $display("FAIL clr_lost_push: got %h want 88", rd_data); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL clr_post_empty: got %b want 1", empty); end
  endtask

  task automatic test_async_reset_thresh();
    do_clr();
    irq_en = 1'b1;
    for (int i = 1; i <= 6; i++) send(8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 3; i++) pop();
    n_cmp++; if (count !== 5'd3 || rd_data !== 8'h33) begin n_fail++; $display("FAIL ar_pre: got %0d/%h want 3/33", count, rd_data); end
    n_cmp++; if (irq4 !== 1'b0) begin n_fail++; $display("FAIL ar_irq4_at3: got %b want 0", irq4); end
    #2 rstN = 1'b0;
    #1;
    n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL ar_count: got %0d want 0", count); end
    n_cmp++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL ar_rd_data: got %h want 00", rd_data); end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL ar_flags: got e%b f%b want e1 f0", empty, full); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ar_irq: got %b want 0", irq); end
    rx_busy = 1'b1;
    tick();
    rx_busy = 1'b0;
    tick();
    n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL ar_frame_in_reset: got %0d want 0", count); end
    rx_data = 8'h41; rx_busy = 1'b1;
    #2 rstN = 1'b1;
    tick();
    rx_busy = 1'b0;
    tick();
    n_cmp++; if (count !== 5'd1) begin n_fail++; $display("FAIL ar_release_push: got %0d want 1", count); end
    n_cmp++; if (irq4 !== 1'b0) begin n_fail++; $display("FAIL th_irq4_at1: got %b want 0", irq4); end
    for (int i = 2; i <= 4; i++) begin
      send(8'(8'h40 + i), 1'b0);
      n_cmp++; if (irq4 !== (i >= 4)) begin n_fail++; $display("FAIL th_irq4_at%0d: got %b want %b", i, irq4, i >= 4); end
    end
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL th_irq_default: got %b want 1", irq); end
    pop();
    n_cmp++; if (rd_data !== 8'h41) begin n_fail++; $display("FAIL th_first_pop: got %h want 41", rd_data); end
  endtask

  initial begin
    rstN = 1'b0; rx_data = '0; rx_busy = 1'b0; rx_check_error = 1'b0;
    irq_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
    tick();
    test_reset();
    test_single();
    test_fill();
    test_full_push_pop();
    test_wrap_err();
    test_clr();
    test_async_reset_thresh();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
